uart_receiver: RTL and testbench

Serial-to-parallel UART receiver. It consumes the 16x-oversampling tick produced by the baud rate generator and recovers frames from the asynchronous rx line. Frames carry 5-8 data bits, LSB first, optional even/odd parity and 1 or 2 stop bits. The block delivers bytes to the register block through a valid/read handshake and reports parity, framing and overrun errors.

---
 rtl/uart_receiver.sv | 260 ++++++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   Serial-to-parallel UART receiver driven by a 16x oversampling tick.
//   Recovers frames of 5-8 data bits (LSB first), optional even/odd parity and
//   1 or 2 stop bits, then hands the byte to the register block through a
//   valid/read handshake together with parity, framing and overrun flags.
//
// Ports:
//   clk_i            system clock
//   rst_i            synchronous, active-high reset
//   rx_i             asynchronous serial line, idle high
//   ov_baud_rt_i     one-clock tick at 16x the baud rate
//   data_width_i     00=5, 01=6, 10=7, 11=8 data bits
//   parity_en_i      a parity bit follows the data
//   parity_odd_i     0 = even parity, 1 = odd parity
//   stop_bits_i      0 = one stop bit, 1 = two stop bits
//   data_read_i      one-clock pulse: register block consumed rx_data_o
//   rx_data_o        received data, right-aligned, unused upper bits 0
//   rx_valid_o       rx_data_o holds an unread frame
//   parity_error_o   parity mismatch on the frame in rx_data_o
//   frame_error_o    a stop bit sampled 0 on the frame in rx_data_o
//   overrun_error_o  sticky: a frame completed while rx_valid_o was high
//   rx_idle_o        receiver FSM is idle
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       ov_baud_rt_i,
  input  logic [1:0] data_width_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       stop_bits_i,
  input  logic       data_read_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       parity_error_o,
  output logic       frame_error_o,
  output logic       overrun_error_o,
  output logic       rx_idle_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // rx_i synchronizer; resets to the idle-line level so reset never looks
  // like a start bit.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours (shift chains work).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;          // 16x tick counter within a bit
  logic [2:0]  idx_q, idx_d;          // data bit index
  logic        armed_q, armed_d;      // line seen high since last frame/reset
  logic [7:0]  shift_q, shift_d;      // data bits of the frame in flight
  logic        par_bit_q, par_bit_d;  // sampled parity bit
  logic        stop_err_q, stop_err_d;
  logic        stop2nd_q, stop2nd_d;  // currently in the second stop bit
  logic        done_q, done_d;        // final stop sample taken last clock

  // Frame configuration, captured at start detection
  logic [1:0]  width_q, width_d;
  logic        par_en_q, par_en_d;
  logic        par_odd_q, par_odd_d;
  logic        stop2_q, stop2_d;

  // Register-block facing outputs
  logic [7:0]  rx_data_q, rx_data_d;
  logic        valid_q, valid_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  logic        frame_perr;

  // Even parity: data XOR parity bit must be 0; odd parity: must be 1.
  // Unused upper shift bits are cleared at start so they do not disturb ^.
  assign frame_perr = par_en_q & ((^shift_q ^ par_bit_q) != par_odd_q);

  // NOTE: every variable driven here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    armed_d    = armed_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    stop_err_d = stop_err_q;
    stop2nd_d  = stop2nd_q;
    done_d     = 1'b0;
    width_d    = width_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    rx_data_d  = rx_data_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;

    if (ov_baud_rt_i) begin
      cnt_d = cnt_q + 4'd1;
      unique case (state_q)
        ST_IDLE: begin
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            // Disarm for the duration of the frame; completion re-arms.
            state_d    = ST_START;
            cnt_d      = 4'd0;
            armed_d    = 1'b0;
            shift_d    = 8'h00;
            par_bit_d  = 1'b0;
            stop_err_d = 1'b0;
            stop2nd_d  = 1'b0;
            width_d    = data_width_i;
            par_en_d   = parity_en_i;
            par_odd_d  = parity_odd_i;
            stop2_d    = stop_bits_i;
          end
        end
        ST_START: begin
          if (cnt_q == 4'd7) begin
            if (rx_s) begin
              state_d = ST_IDLE;  // false start
            end else begin
              state_d = ST_DATA;
              cnt_d   = 4'd0;
              idx_d   = 3'd0;
            end
          end
        end
        ST_DATA: begin
          if (cnt_q == 4'd15) begin
            shift_d[idx_q] = rx_s;
            idx_d          = idx_q + 3'd1;
            // Last index is width-1 = 4 + data_width.
            if (idx_q == {1'b1, width_q}) begin
              state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (cnt_q == 4'd15) begin
            par_bit_d = rx_s;
            state_d   = ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt_q == 4'd15) begin
            if (!rx_s) begin
              stop_err_d = 1'b1;
            end
            if (stop2_q && !stop2nd_q) begin
              stop2nd_d = 1'b1;
            end else begin
              // Leave at mid-stop-bit so a back-to-back start is caught.
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Completion overrides the IDLE arming above; a read in the same clock
    // retires the old frame, so it suppresses the overrun.
    if (done_q) begin
      rx_data_d = shift_q;
      perr_d    = frame_perr;
      ferr_d    = stop_err_q;
      valid_d   = 1'b1;
      armed_d   = ~stop_err_q;
      if (valid_q && !data_read_i) begin
        ovr_d = 1'b1;
      end else if (valid_q && data_read_i) begin
        ovr_d = 1'b0;
      end
    end else if (valid_q && data_read_i) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= 3'd0;
      armed_q    <= 1'b0;
      shift_q    <= 8'h00;
      par_bit_q  <= 1'b0;
      stop_err_q <= 1'b0;
      stop2nd_q  <= 1'b0;
      done_q     <= 1'b0;
      width_q    <= 2'd0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      rx_data_q  <= 8'h00;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      armed_q    <= armed_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      stop_err_q <= stop_err_d;
      stop2nd_q  <= stop2nd_d;
      done_q     <= done_d;
      width_q    <= width_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      rx_data_q  <= rx_data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data_o       = rx_data_q;
  assign rx_valid_o      = valid_q;
  assign parity_error_o  = perr_q;
  assign frame_error_o   = ferr_q;
  assign overrun_error_o = ovr_q;
  assign rx_idle_o       = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//   Directed bench for uart_receiver. A 16x tick arrives every 4 clocks, so
//   one bit on the line lasts 64 clocks. Inputs change on the falling edge and
//   outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       ov_baud_rt_i = 1'b0;
  logic [1:0] data_width_i = 2'b11;
  logic       parity_en_i = 1'b0;
  logic       parity_odd_i = 1'b0;
  logic       stop_bits_i = 1'b0;
  logic       data_read_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       parity_error_o;
  logic       frame_error_o;
  logic       overrun_error_o;
  logic       rx_idle_o;

  int checks = 0;
  int errors = 0;

  localparam int BIT_CLKS = 64;

  uart_receiver #(.SYNC_STAGES(2)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rx_i            (rx_i),
    .ov_baud_rt_i    (ov_baud_rt_i),
    .data_width_i    (data_width_i),
    .parity_en_i     (parity_en_i),
    .parity_odd_i    (parity_odd_i),
    .stop_bits_i     (stop_bits_i),
    .data_read_i     (data_read_i),
    .rx_data_o       (rx_data_o),
    .rx_valid_o      (rx_valid_o),
    .parity_error_o  (parity_error_o),
    .frame_error_o   (frame_error_o),
    .overrun_error_o (overrun_error_o),
    .rx_idle_o       (rx_idle_o)
  );

  always #5 clk_i = ~clk_i;

  // Tick generator: high for one full clock out of every four.
  logic [1:0] div = 2'd0;
  always @(negedge clk_i) begin
    div = div + 2'd1;
    ov_baud_rt_i = (div == 2'd0);
  end

  // Rising edges since the last edge that sampled a tick, and its value at
  // the moment rx_valid_o was last seen rising.
  int tick_age = 0;
  int rise_age = -1;
  logic prev_valid = 1'b0;
  always @(posedge clk_i) begin
    if (ov_baud_rt_i) tick_age = 0;
    else tick_age = tick_age + 1;
  end
  always @(negedge clk_i) begin
    if (rx_valid_o && !prev_valid) rise_age = tick_age;
    prev_valid = rx_valid_o;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input logic par_bit, input int nstop, input logic stop_val);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (par_en) send_bit(par_bit);
    for (int i = 0; i < nstop; i++) send_bit(stop_val);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!rx_valid_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, " valid"}, {7'd0, rx_valid_o}, 8'd1);
  endtask

  task automatic read_pulse();
    data_read_i = 1'b1;
    @(negedge clk_i);
    data_read_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic set_8n1();
    data_width_i = 2'b11;
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    stop_bits_i  = 1'b0;
  endtask

  initial begin
    bit saw_busy;

    // ---------------- reset values ----------------
    repeat (5) @(negedge clk_i);
    check("rst data", rx_data_o, 8'h00);
    check("rst valid", {7'd0, rx_valid_o}, 8'd0);
    check("rst perr", {7'd0, parity_error_o}, 8'd0);
    check("rst ferr", {7'd0, frame_error_o}, 8'd0);
    check("rst ovr", {7'd0, overrun_error_o}, 8'd0);
    check("rst idle", {7'd0, rx_idle_o}, 8'd1);
    rst_i = 1'b0;
    repeat (BIT_CLKS) @(negedge clk_i);

    // ---------------- 1: 8N1 0xA5 ----------------
    set_8n1();
    send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1);
    wait_valid("t1");
    check("t1 data", rx_data_o, 8'hA5);
    check("t1 perr", {7'd0, parity_error_o}, 8'd0);
    check("t1 ferr", {7'd0, frame_error_o}, 8'd0);
    check("t1 ovr", {7'd0, overrun_error_o}, 8'd0);
    check("t1 valid latency", rise_age[7:0], 8'd1);
    read_pulse();
    check("t1 read valid", {7'd0, rx_valid_o}, 8'd0);
    check("t1 read data hold", rx_data_o, 8'hA5);

    // ---------------- 2: 7E2, parity good then bad ----------------
    // 0x53 = 101_0011: four ones, so the even parity bit is 0.
    data_width_i = 2'b10;
    parity_en_i  = 1'b1;
    parity_odd_i = 1'b0;
    stop_bits_i  = 1'b1;
    send_frame(8'h53, 7, 1, 1'b0, 2, 1'b1);
    wait_valid("t2a");
    check("t2a data", rx_data_o, 8'h53);
    check("t2a perr", {7'd0, parity_error_o}, 8'd0);
    check("t2a ferr", {7'd0, frame_error_o}, 8'd0);
    read_pulse();
    send_frame(8'h53, 7, 1, 1'b1, 2, 1'b1);
    wait_valid("t2b");
    check("t2b data", rx_data_o, 8'h53);
    check("t2b perr", {7'd0, parity_error_o}, 8'd1);
    read_pulse();
    set_8n1();
    repeat (BIT_CLKS) @(negedge clk_i);

    // ---------------- 3: 5-tick glitch, then 0x3C ----------------
    rx_i = 1'b0;
    repeat (16) @(negedge clk_i);
    check("t3 glitch busy", {7'd0, rx_idle_o}, 8'd0);
    repeat (4) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (60) @(negedge clk_i);
    check("t3 false start idle", {7'd0, rx_idle_o}, 8'd1);
    check("t3 false start valid", {7'd0, rx_valid_o}, 8'd0);
    send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b1);
    wait_valid("t3");
    check("t3 data", rx_data_o, 8'h3C);
    read_pulse();
    repeat (BIT_CLKS) @(negedge clk_i);

    // ---------------- 4: back-to-back overrun ----------------
    send_frame(8'h11, 8, 0, 1'b0, 1, 1'b1);
    send_frame(8'h22, 8, 0, 1'b0, 1, 1'b1);
    wait_valid("t4");
    check("t4 data", rx_data_o, 8'h22);
    check("t4 ovr", {7'd0, overrun_error_o}, 8'd1);
    read_pulse();
    check("t4 read valid", {7'd0, rx_valid_o}, 8'd0);
    check("t4 read ovr", {7'd0, overrun_error_o}, 8'd0);
    repeat (BIT_CLKS) @(negedge clk_i);

    // ---------------- 5: framing error, held break, then 0x7E ----------------
    send_frame(8'h5A, 8, 0, 1'b0, 1, 1'b0);
    wait_valid("t5");
    check("t5 data", rx_data_o, 8'h5A);
    check("t5 ferr", {7'd0, frame_error_o}, 8'd1);
    read_pulse();
    repeat (160) @(negedge clk_i);
    check("t5 break idle", {7'd0, rx_idle_o}, 8'd1);
    check("t5 break valid", {7'd0, rx_valid_o}, 8'd0);
    rx_i = 1'b1;
    repeat (BIT_CLKS) @(negedge clk_i);
    send_frame(8'h7E, 8, 0, 1'b0, 1, 1'b1);
    wait_valid("t5b");
    check("t5b data", rx_data_o, 8'h7E);
    check("t5b ferr", {7'd0, frame_error_o}, 8'd0);
    check("t5b ovr", {7'd0, overrun_error_o}, 8'd0);

    // ---------------- 6: reset during DATA ----------------
    // 0x7E is left unread so reset has something visible to clear.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx_i  = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("t6 rst data", rx_data_o, 8'h00);
    check("t6 rst valid", {7'd0, rx_valid_o}, 8'd0);
    check("t6 rst ferr", {7'd0, frame_error_o}, 8'd0);
    check("t6 rst perr", {7'd0, parity_error_o}, 8'd0);
    check("t6 rst ovr", {7'd0, overrun_error_o}, 8'd0);
    check("t6 rst idle", {7'd0, rx_idle_o}, 8'd1);
    // Release just after a tick so the reset-high synchronizer has flushed
    // to the low line level before the next tick.
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    while (!ov_baud_rt_i) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    saw_busy = 1'b0;
    repeat (200) begin
      @(negedge clk_i);
      if (!rx_idle_o) saw_busy = 1'b1;
    end
    check("t6 low line no start", {7'd0, saw_busy}, 8'd0);
    rx_i = 1'b1;
    repeat (BIT_CLKS) @(negedge clk_i);
    send_frame(8'h96, 8, 0, 1'b0, 1, 1'b1);
    wait_valid("t6");
    check("t6 data", rx_data_o, 8'h96);
    check("t6 ovr", {7'd0, overrun_error_o}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
